// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS pipeline.
//   stateT      : fetch controller state (LOAD=0, RUN=1, HALTED=2)
//   NOP_INSTR   : instruction word injected into IF/ID on flush and while draining
//   HALT_INSTR  : default opcode pattern that stops fetch
package if_stage_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } stateT;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  // Word index of a byte PC into an instruction memory of 2**addrW words.
  // Upper PC bits are dropped, so fetch addresses wrap modulo the memory depth.
  function automatic logic [31:0] pcToWordIndex(input logic [31:0] pc, input int unsigned addrW);
    logic [31:0] mask;
    mask = (32'h1 << addrW) - 32'h1;
    return (pc >> 2) & mask;
  endfunction

endpackage

// File: rtl/if_stage_imem.sv
// InstructionMemory: IMEM_DEPTH x 32 instruction store for the fetch stage.
// Combinational read so the fetched word is available in the same cycle as the PC;
// synchronous write used only while the program is being loaded.
// Contents are deliberately not reset so a program survives a pipeline reset.
//   Clock         in   rising-edge clock
//   WriteEnable   in   write strobe (already qualified by the caller)
//   WriteAddr     in   word address of the write
//   WriteData     in   word to store
//   ReadAddr      in   word address of the fetch
//   ReadData      out  word at ReadAddr
module InstructionMemory #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              Clock,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [31:0]       WriteData,
  input  logic [ADDR_W-1:0] ReadAddr,
  output logic [31:0]       ReadData
);

  logic [31:0] mem [IMEM_DEPTH];

  always_ff @(posedge Clock) begin
    if (WriteEnable) begin
      mem[WriteAddr] <= WriteData;
    end
  end

  assign ReadData = mem[ReadAddr];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage; producer side of the IF/ID interface.
// Holds the PC, the on-chip instruction memory and the IF/ID register, follows the
// stall / flush / redirect controls resolved in ID, and stops fetching on HALT.
//   Clock, Reset     clock and synchronous active-high reset
//   Enable           0 freezes all state including memory writes
//   Start            LOAD -> RUN request
//   InstrWrite/Addr/Data  program-load port (LOAD state only)
//   PCWrite          0 holds the PC
//   IFIDWrite        0 holds the IF/ID register (wins over Flush_IF)
//   Flush_IF         replaces the fetched word with NOP
//   JumpControl/JumpAddress   jump redirect from ID
//   BranchFlag/BranchOffset   taken-branch redirect from ID (wins over jump)
//   Out_Instruction, PCAdder  IF/ID register contents (instruction, PC+4)
//   PC_Out           current fetch PC
//   Halted           1 while in HALTED
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] HALT_INSTR = if_stage_pkg::HALT_INSTR
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Start,
  input  logic              InstrWrite,
  input  logic [ADDR_W-1:0] InstrWriteAddr,
  input  logic [31:0]       InstrWriteData,
  input  logic              PCWrite,
  input  logic              IFIDWrite,
  input  logic              Flush_IF,
  input  logic              JumpControl,
  input  logic [31:0]       JumpAddress,
  input  logic              BranchFlag,
  input  logic [31:0]       BranchOffset,
  output logic [31:0]       Out_Instruction,
  output logic [31:0]       PCAdder,
  output logic [31:0]       PC_Out,
  output logic              Halted
);

  stateT       state;
  logic [31:0] pc;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        haltedReg;

  logic [31:0] fetchWord;
  logic [31:0] fetchIndex;
  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic [31:0] nextPc;
  logic        memWrite;
  logic        haltFetch;

  // Memory writes share the state-register priority: reset and freeze both block them.
  assign memWrite = InstrWrite && Enable && !Reset && (state == LOAD);

  assign fetchIndex = pcToWordIndex(pc, ADDR_W);

  InstructionMemory #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) imem (
    .Clock       (Clock),
    .WriteEnable (memWrite),
    .WriteAddr   (InstrWriteAddr),
    .WriteData   (InstrWriteData),
    .ReadAddr    (fetchIndex[ADDR_W-1:0]),
    .ReadData    (fetchWord)
  );

  // Branch target is relative to the ID instruction's PC+4, i.e. the IF/ID PCAdder.
  always_comb begin
    pcPlus4      = pc + 32'd4;
    branchTarget = ifidPcPlus4 + (BranchOffset << 2);
    if (BranchFlag) begin
      nextPc = branchTarget;
    end else if (JumpControl) begin
      nextPc = JumpAddress;
    end else begin
      nextPc = pcPlus4;
    end
  end

  // A HALT only takes effect when it would actually enter IF/ID unflushed and the
  // PC is free to move; otherwise it is either discarded or re-fetched later.
  assign haltFetch = (fetchWord == HALT_INSTR) && IFIDWrite && PCWrite && !Flush_IF;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= LOAD;
      pc          <= '0;
      ifidInstr   <= NOP_INSTR;
      ifidPcPlus4 <= '0;
      haltedReg   <= 1'b0;
    end else if (Enable) begin
      case (state)
        LOAD: begin
          if (Start) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          if (haltFetch) begin
            ifidInstr   <= HALT_INSTR;
            ifidPcPlus4 <= pcPlus4;
            state       <= HALTED;
            haltedReg   <= 1'b1;
          end else begin
            if (PCWrite) begin
              pc <= nextPc;
            end
            if (IFIDWrite) begin
              ifidInstr   <= Flush_IF ? NOP_INSTR : fetchWord;
              ifidPcPlus4 <= pcPlus4;
            end
          end
        end
        HALTED: begin
          // Feed bubbles so the instructions ahead of HALT drain out of the pipe.
          ifidInstr <= NOP_INSTR;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  assign Out_Instruction = ifidInstr;
  assign PCAdder         = ifidPcPlus4;
  assign PC_Out          = pc;
  assign Halted          = haltedReg;

endmodule
